// File: rtl/radix_2_dif_intt16.sv
// radix_2_dif_intt16
// Sequential 16-point inverse NTT over Z_65537 with omega = 4 and omega^-1 = 2^30.
// Gentleman-Sande radix-2 DIF core. A 16-word register file holds the frame, one butterfly
// runs per cycle (4 stages x 8 butterflies), and outputs are scaled by 16^-1 = -2^12 on the
// drain path. Twiddles are powers of two, so every multiply is a shift plus 2^16 = -1 folding.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input handshake, in_data = A[k], natural order
//   out_valid/out_ready  output handshake, out_data = a[j], natural order
//   out_last             high with out_valid on j = 15
//   busy                 high while computing or draining
module radix_2_dif_intt16 #(
  parameter int unsigned N = 17  // coefficient width; the datapath assumes Q = 65537
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam logic [N-1:0] Q = N'(65537);
  // 16^-1 = -2^12 = 2^28 (mod Q), expressed as a power-of-two shift.
  localparam logic [4:0] NinvShift = 5'd28;

  typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_e;

  state_e       r_state, w_state_nxt;
  logic [4:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0] r_mem [16];

  // (x + y) mod Q; the N-bit wrap of the subtraction yields the right residue.
  function automatic logic [N-1:0] f_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) return s[N-1:0] - Q;
    return s[N-1:0];
  endfunction

  // (x - y) mod Q for x, y in [0, Q-1].
  function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, input logic [N-1:0] y);
    if (x >= y) return x - y;
    return x - y + Q;
  endfunction

  // x * 2^s mod Q for s in [0, 31]. 2^s = (-1)^s[4] * 2^s[3:0]; the shifted product is split
  // into 16-bit digits d0 + d1*2^16 + d2*2^32 == d0 - d1 + d2.
  function automatic logic [N-1:0] f_mul_pow2(input logic [N-1:0] x, input logic [4:0] s);
    logic [2*N-2:0] p;
    logic [15:0]    d0, d1;
    logic           d2;
    logic [N-1:0]   a, r;
    p  = {{(N-1){1'b0}}, x} << s[3:0];
    d0 = p[15:0];
    d1 = p[31:16];
    d2 = p[32];
    a  = {1'b0, d0} + {16'b0, d2};
    if (a >= {1'b0, d1}) r = a - {1'b0, d1};
    else                 r = a + Q - {1'b0, d1};
    if (s[4] && (r != '0)) r = Q - r;
    return r;
  endfunction

  // Butterfly addressing: r_cnt[4:3] is the stage, r_cnt[2:0] the butterfly within it.
  logic [1:0]   w_stage;
  logic [2:0]   w_bf;
  logic [3:0]   w_idx_x, w_idx_y;
  logic [2:0]   w_exp;     // twiddle exponent of omega^-1
  logic [4:0]   w_shift;   // omega^-e = 2^(-2e mod 32)
  logic [N-1:0] w_x, w_y, w_sum, w_dif, w_prod;
  logic [N-1:0] w_in_red;
  logic [3:0]   w_rev;

  assign w_stage = r_cnt[4:3];
  assign w_bf    = r_cnt[2:0];

  always_comb begin
    w_idx_x = 4'd0;
    w_idx_y = 4'd0;
    w_exp   = 3'd0;
    unique case (w_stage)
      2'd0: begin
        w_idx_x = {1'b0, w_bf};
        w_idx_y = {1'b1, w_bf};
        w_exp   = w_bf;
      end
      2'd1: begin
        w_idx_x = {w_bf[2], 1'b0, w_bf[1:0]};
        w_idx_y = {w_bf[2], 1'b1, w_bf[1:0]};
        w_exp   = {w_bf[1:0], 1'b0};
      end
      2'd2: begin
        w_idx_x = {w_bf[2:1], 1'b0, w_bf[0]};
        w_idx_y = {w_bf[2:1], 1'b1, w_bf[0]};
        w_exp   = {w_bf[0], 2'b00};
      end
      2'd3: begin
        w_idx_x = {w_bf, 1'b0};
        w_idx_y = {w_bf, 1'b1};
        w_exp   = 3'd0;
      end
      default: ;
    endcase
  end

  assign w_shift  = 5'd0 - {1'b0, w_exp, 1'b0};
  assign w_x      = r_mem[w_idx_x];
  assign w_y      = r_mem[w_idx_y];
  assign w_sum    = f_add(w_x, w_y);
  assign w_dif    = f_sub(w_x, w_y);
  assign w_prod   = f_mul_pow2(w_dif, w_shift);
  assign w_in_red = (in_data >= Q) ? in_data - Q : in_data;

  // DIF with natural-order input leaves results in bit-reversed slots.
  assign w_rev = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};

  // Next-state and outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    busy        = 1'b0;
    unique case (r_state)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_cnt == 5'd15) begin
            w_state_nxt = StCompute;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      StCompute: begin
        busy = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = StDrain;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      StDrain: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (r_cnt == 5'd15);
        out_data  = f_mul_pow2(r_mem[w_rev], NinvShift);
        if (out_ready) begin
          if (r_cnt == 5'd15) begin
            w_state_nxt = StLoad;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = StLoad;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StLoad;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Register file has no reset; contents are rewritten by every frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_ready && in_valid) begin
        r_mem[r_cnt[3:0]] <= w_in_red;
      end else if (r_state == StCompute) begin
        r_mem[w_idx_x] <= w_sum;
        r_mem[w_idx_y] <= w_prod;
      end
    end
  end

endmodule

// File: tb/tb_radix_2_dif_intt16.sv
// tb_radix_2_dif_intt16
// Self-checking bench for radix_2_dif_intt16: directed vector table, random round-trip frames
// through a forward-NTT model, backpressure stalls and mid-frame resets.
module tb_radix_2_dif_intt16;

  localparam longint unsigned QM = 65537;

  typedef logic [15:0][16:0] frame_t;
  typedef struct packed {
    frame_t a_in;
    frame_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vecs [4];

  radix_2_dif_intt16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned modpow(input longint unsigned b, input int unsigned e);
    longint unsigned r = 1;
    for (int i = 0; i < int'(e); i++) r = (r * b) % QM;
    return r;
  endfunction

  // a[j] = 16^-1 * sum_k A[k] * omega^(-jk), omega^-1 = 49153.
  task automatic model_intt(input frame_t fa, output frame_t ta);
    for (int j = 0; j < 16; j++) begin
      longint unsigned acc = 0;
      for (int k = 0; k < 16; k++)
        acc = (acc + (longint'(fa[k]) % QM) * modpow(49153, (j * k) % 16)) % QM;
      ta[j] = 17'((acc * 61441) % QM);
    end
  endtask

  // A[k] = sum_j a[j] * 4^(jk).
  task automatic model_ntt(input frame_t ta, output frame_t fa);
    for (int k = 0; k < 16; k++) begin
      longint unsigned acc = 0;
      for (int j = 0; j < 16; j++)
        acc = (acc + longint'(ta[j]) * modpow(4, (j * k) % 16)) % QM;
      fa[k] = 17'(acc);
    end
  endtask

  // Drives cnt words; returns right after the rising edge of the last transfer.
  task automatic send_inputs(input frame_t fa, input int cnt, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      int g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fa[k];
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g == 100) begin
        chk("in_ready_timeout", 0, 1);
        ok = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  // mode 0: out_ready always high; 1: random; 2: random plus 20 stalled cycles on j=7.
  task automatic run_frame(input frame_t fa, input int mode, output frame_t got);
    bit          ok;
    int          m, j, guard, stall7, stab_err, valid_err, ovl_err;
    logic [16:0] prev_d;
    logic        prev_l, stalled, rdy;
    logic [15:0] last_mask;
    got = '0;
    send_inputs(fa, 16, ok);
    if (!ok) return;
    @(negedge clk);
    chk("busy_no_ready_compute", {busy, in_ready}, 2'b10);
    // in_valid must be ignored while computing
    in_valid = 1'b1;
    in_data  = 17'($urandom);
    m = 0;
    while (!out_valid && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("latency", m, 32);
    in_valid = 1'b0;
    if (m == 200) return;
    j = 0; guard = 0; stall7 = 0; stab_err = 0; valid_err = 0; ovl_err = 0;
    stalled = 1'b0; prev_d = '0; prev_l = 1'b0; last_mask = '0;
    while (j < 16 && guard < 3000) begin
      guard++;
      if (!out_valid) valid_err++;
      if (in_ready) ovl_err++;
      if (stalled && (out_data !== prev_d || out_last !== prev_l)) stab_err++;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 2 && j == 7 && stall7 < 20) begin
        rdy = 1'b0;
        stall7++;
      end else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (rdy) begin
        got[j]       = out_data;
        last_mask[j] = out_last;
        j++;
      end
      stalled = !rdy;
      prev_d  = out_data;
      prev_l  = out_last;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("frame_complete", j, 16);
    chk("out_valid_held", valid_err, 0);
    chk("in_ready_low_drain", ovl_err, 0);
    chk("stall_stable", stab_err, 0);
    chk("out_last_pattern", last_mask, 16'h8000);
    chk("post_frame_flags", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    frame_t fa, ta, got;
    bit     ok;
    int     seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Directed vector table.
    for (int k = 0; k < 16; k++) begin
      vecs[0].a_in[k] = (k == 0) ? 17'd16 : 17'd0;
      vecs[0].exp[k]  = 17'd1;
      vecs[1].a_in[k] = 17'd1;
      vecs[1].exp[k]  = (k == 0) ? 17'd1 : 17'd0;
      vecs[2].a_in[k] = (k == 1) ? 17'd1 : 17'd0;
      vecs[2].exp[k]  = 17'((61441 * modpow(49153, k)) % QM);
      vecs[3].a_in[k] = 17'($urandom_range(0, 65536));
    end
    vecs[3].a_in[3] = 17'd65540;
    model_intt(vecs[3].a_in, ta);
    vecs[3].exp = ta;

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].a_in, v % 2, got);
      for (int k = 0; k < 16; k++)
        chk($sformatf("vec%0d_a%0d", v, k), got[k], vecs[v].exp[k]);
      if (v == 2) begin
        chk("a0_ninv", got[0], 61441);
        chk("a1_2pow26", got[1], 64513);
      end
    end

    // Random round trips through the forward model.
    for (int f = 0; f < 50; f++) begin
      int mode;
      if (f == 0) begin
        for (int k = 0; k < 16; k++) fa[k] = 17'($urandom_range(0, 65536));
        fa[0] = 17'd3;
        model_intt(fa, ta);
        fa[0] = 17'd65540;  // captured as 3
      end else begin
        for (int k = 0; k < 16; k++) ta[k] = 17'($urandom_range(0, 65536));
        model_ntt(ta, fa);
      end
      mode = (f == 10) ? 2 : ((f % 3 == 0) ? 1 : 0);
      run_frame(fa, mode, got);
      for (int k = 0; k < 16; k++)
        chk($sformatf("rt%0d_a%0d", f, k), got[k], ta[k]);
    end

    // Abort during COMPUTE cycle 10.
    for (int k = 0; k < 16; k++) fa[k] = 17'($urandom_range(0, 65536));
    send_inputs(fa, 16, ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_flags", {in_ready, out_valid, busy, out_last}, 4'b1000);
    chk("abort_out_data", out_data, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("abort_no_output", seen, 0);
    for (int k = 0; k < 16; k++) ta[k] = 17'($urandom_range(0, 65536));
    model_ntt(ta, fa);
    run_frame(fa, 1, got);
    for (int k = 0; k < 16; k++)
      chk($sformatf("after_abort_a%0d", k), got[k], ta[k]);

    // Abort part way through LOAD.
    for (int k = 0; k < 16; k++) fa[k] = 17'($urandom_range(0, 65536));
    send_inputs(fa, 5, ok);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) ta[k] = 17'($urandom_range(0, 65536));
    model_ntt(ta, fa);
    run_frame(fa, 0, got);
    for (int k = 0; k < 16; k++)
      chk($sformatf("after_load_abort_a%0d", k), got[k], ta[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
